// File: rtl/motor_pwm_mixer.sv
// Left/right PWM generator mixing a signed steering delta into a base duty.
// Optional macro SLEW_LIMIT_EN: duty changes ramp by at most MAX_STEP per PWM period.
module motor_pwm_mixer #(
  parameter int PWM_BITS  = 8,
  parameter int DELTA_W   = 8,
  parameter int BASE_DUTY = 128,
  parameter int PRESCALE  = 4,
  parameter int MAX_STEP  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DELTA_W-1:0]  delta,
  input  logic                delta_valid,
  output logic                delta_ready,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic                period_start,
  output logic                dbg_state
);

  localparam logic ST_DISABLED = 1'b0;
  localparam logic ST_RUN      = 1'b1;

`ifdef SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  localparam int EXT_W = PWM_BITS + 2;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]         PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic signed [EXT_W-1:0] DUTY_MAX_X = EXT_W'((1 << PWM_BITS) - 1);
  localparam logic signed [EXT_W-1:0] BASE_X     = EXT_W'(BASE_DUTY);
  localparam logic [PWM_BITS-1:0]     BASE_INIT  = PWM_BITS'(BASE_DUTY);
  localparam logic signed [PWM_BITS:0] STEP_X    = (PWM_BITS + 1)'(MAX_STEP);

  // Handshake: a delta transfers on any rising clk edge where delta_valid and
  // delta_ready are both high; delta_ready never depends on delta_valid.

  logic                state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic [PWM_BITS-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
  logic [PWM_BITS-1:0] active_l_q, active_l_d, active_r_q, active_r_d;
  logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic                pstart_q, pstart_d;

  logic                    tick, boundary, accept, settled;
  logic signed [EXT_W-1:0] delta_x, sum_l, sum_r;
  logic [PWM_BITS-1:0]     next_l, next_r;

  function automatic logic [PWM_BITS-1:0] saturate(input logic signed [EXT_W-1:0] v);
    logic [PWM_BITS-1:0] r;
    if (v[EXT_W-1])
      r = '0;
    else if (v > DUTY_MAX_X)
      r = '1;
    else
      r = v[PWM_BITS-1:0];
    return r;
  endfunction

  // Step cur toward target, never overshooting; a gap within MAX_STEP lands exactly.
  function automatic logic [PWM_BITS-1:0] approach(input logic [PWM_BITS-1:0] cur,
                                                   input logic [PWM_BITS-1:0] target);
    logic signed [PWM_BITS:0] diff;
    logic [PWM_BITS-1:0]      r;
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    if (diff > STEP_X)
      r = cur + PWM_BITS'(MAX_STEP);
    else if (diff < -STEP_X)
      r = cur - PWM_BITS'(MAX_STEP);
    else
      r = target;
    return r;
  endfunction

  assign delta_x = {{(EXT_W - DELTA_W){delta[DELTA_W-1]}}, delta};
  assign sum_l   = BASE_X + delta_x;
  assign sum_r   = BASE_X - delta_x;

  assign next_l  = SLEW_ON ? approach(active_l_q, shadow_l_q) : shadow_l_q;
  assign next_r  = SLEW_ON ? approach(active_r_q, shadow_r_q) : shadow_r_q;
  assign settled = (next_l == shadow_l_q) && (next_r == shadow_r_q);

  assign tick        = (presc_q == PS_LAST);
  assign delta_ready = (state_q == ST_RUN) && !pending_q;
  assign accept      = delta_valid && delta_ready;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    active_l_d = active_l_q;
    active_r_d = active_r_q;
    pwm_l_d    = 1'b0;
    pwm_r_d    = 1'b0;
    boundary   = 1'b0;

    case (state_q)
      ST_DISABLED: begin
        presc_d    = '0;
        cnt_d      = '0;
        active_l_d = '0;
        active_r_d = '0;
        // Entering RUN is itself a period boundary: the counter sits at 0 next cycle.
        if (enable) begin
          state_d  = ST_RUN;
          boundary = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          state_d    = ST_DISABLED;
          presc_d    = '0;
          cnt_d      = '0;
          active_l_d = '0;
          active_r_d = '0;
        end else begin
          presc_d  = tick ? '0 : presc_q + PS_W'(1);
          cnt_d    = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
          boundary = tick && (cnt_q == '1);
          pwm_l_d  = (cnt_q < active_l_q);
          pwm_r_d  = (cnt_q < active_r_q);
        end
      end
    endcase

    pstart_d = boundary;

    // Boundary consumes the pre-edge shadow, so a coincident accept waits a period.
    if (boundary) begin
      active_l_d = next_l;
      active_r_d = next_r;
      if (settled) pending_d = 1'b0;
    end

    if (accept) begin
      shadow_l_d = saturate(sum_l);
      shadow_r_d = saturate(sum_r);
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISABLED;
      presc_q    <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      shadow_l_q <= BASE_INIT;
      shadow_r_q <= BASE_INIT;
      active_l_q <= '0;
      active_r_q <= '0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
      pstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
      active_l_q <= active_l_d;
      active_r_q <= active_r_d;
      pwm_l_q    <= pwm_l_d;
      pwm_r_q    <= pwm_r_d;
      pstart_q   <= pstart_d;
    end
  end

  assign pwm_left     = pwm_l_q;
  assign pwm_right    = pwm_r_q;
  assign duty_left    = active_l_q;
  assign duty_right   = active_r_q;
  assign period_start = pstart_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_motor_pwm_mixer.sv
// Bench for motor_pwm_mixer: two instances (base 128 and base 200) share stimulus and
// are checked every cycle against a period-level behavioural model.
module tb_motor_pwm_mixer;

  localparam int PERIOD   = 256;
  localparam int MAX_STEP = 16;
  localparam int MAXW     = 40 * PERIOD;
`ifdef SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       delta_valid;
  logic [7:0] delta;
  logic       rdy[2];
  logic       pwm_l[2];
  logic       pwm_r[2];
  logic       ps[2];
  logic       dbg[2];
  logic [7:0] duty_l[2];
  logic [7:0] duty_r[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  motor_pwm_mixer #(.PWM_BITS(8), .DELTA_W(8), .BASE_DUTY(128), .PRESCALE(1), .MAX_STEP(MAX_STEP))
  u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delta(delta), .delta_valid(delta_valid),
    .delta_ready(rdy[0]), .pwm_left(pwm_l[0]), .pwm_right(pwm_r[0]),
    .duty_left(duty_l[0]), .duty_right(duty_r[0]), .period_start(ps[0]), .dbg_state(dbg[0])
  );

  motor_pwm_mixer #(.PWM_BITS(8), .DELTA_W(8), .BASE_DUTY(200), .PRESCALE(1), .MAX_STEP(MAX_STEP))
  u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delta(delta), .delta_valid(delta_valid),
    .delta_ready(rdy[1]), .pwm_left(pwm_l[1]), .pwm_right(pwm_r[1]),
    .duty_left(duty_l[1]), .duty_right(duty_r[1]), .period_start(ps[1]), .dbg_state(dbg[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  int  base_of[2] = '{128, 200};
  int  m_sh_l[2], m_sh_r[2], m_act_l[2], m_act_r[2];
  bit  m_pend[2], m_acc[2], m_pwm_l[2], m_pwm_r[2];
  bit  m_run, m_ps;
  int  m_t;

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int sdelta(input logic [7:0] d);
    return int'($signed(d));
  endfunction

  function automatic int approach(input int cur, input int tgt);
    if (SLEW && (tgt - cur > MAX_STEP)) return cur + MAX_STEP;
    if (SLEW && (cur - tgt > MAX_STEP)) return cur - MAX_STEP;
    return tgt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_t   = 0;
    m_ps  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_sh_l[k]  = base_of[k];
      m_sh_r[k]  = base_of[k];
      m_act_l[k] = 0;
      m_act_r[k] = 0;
      m_pend[k]  = 1'b0;
      m_acc[k]   = 1'b0;
      m_pwm_l[k] = 1'b0;
      m_pwm_r[k] = 1'b0;
    end
  endtask

  // Expected state after the coming rising edge, given the inputs now applied.
  task automatic model_edge(input bit en, input bit dv, input logic [7:0] d);
    bit was_run;
    bit bnd;
    bit rdy_before[2];
    was_run = m_run;
    bnd     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rdy_before[k] = m_run && !m_pend[k];
      m_pwm_l[k]    = was_run && en && (m_t < m_act_l[k]);
      m_pwm_r[k]    = was_run && en && (m_t < m_act_r[k]);
    end
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_t   = 0;
        bnd   = 1'b1;
      end
    end else if (!en) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int k = 0; k < 2; k++) begin
        m_act_l[k] = 0;
        m_act_r[k] = 0;
      end
    end else begin
      m_t = (m_t + 1) % PERIOD;
      bnd = (m_t == 0);
    end
    m_ps = bnd;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = dv && rdy_before[k];
      if (bnd) begin
        m_act_l[k] = approach(m_act_l[k], m_sh_l[k]);
        m_act_r[k] = approach(m_act_r[k], m_sh_r[k]);
        if (m_act_l[k] == m_sh_l[k] && m_act_r[k] == m_sh_r[k]) m_pend[k] = 1'b0;
      end
      if (m_acc[k]) begin
        m_sh_l[k] = sat(base_of[k] + sdelta(d));
        m_sh_r[k] = sat(base_of[k] - sdelta(d));
        m_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("duty_left%0d", k),    32'(duty_l[k]), 32'(m_act_l[k]));
      chk($sformatf("duty_right%0d", k),   32'(duty_r[k]), 32'(m_act_r[k]));
      chk($sformatf("delta_ready%0d", k),  32'(rdy[k]),    32'(m_run && !m_pend[k]));
      chk($sformatf("period_start%0d", k), 32'(ps[k]),     32'(m_ps));
      chk($sformatf("pwm_left%0d", k),     32'(pwm_l[k]),  32'(m_pwm_l[k]));
      chk($sformatf("pwm_right%0d", k),    32'(pwm_r[k]),  32'(m_pwm_r[k]));
      chk($sformatf("dbg_state%0d", k),    32'(dbg[k]),    32'(m_run));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_duty_left%0d", tag, k),  32'(duty_l[k]), 32'(0));
      chk($sformatf("%s_duty_right%0d", tag, k), 32'(duty_r[k]), 32'(0));
      chk($sformatf("%s_pwm%0d", tag, k),        32'({pwm_l[k], pwm_r[k]}), 32'(0));
      chk($sformatf("%s_ready%0d", tag, k),      32'(rdy[k]), 32'(0));
      chk($sformatf("%s_pstart%0d", tag, k),     32'(ps[k]), 32'(0));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, advance model, sample at the next falling edge.
  task automatic cyc(input bit en, input bit dv, input logic [7:0] d);
    enable      = en;
    delta_valid = dv;
    delta       = d;
    model_edge(en, dv, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait bound expired, observed timeout, expected event", tag);
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    forever begin
      cyc(1'b1, 1'b1, d);
      if (m_acc[0]) break;
      n++;
      if (n > MAXW) begin timeout("send"); break; end
    end
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    forever begin
      cyc(1'b1, 1'b0, 8'h00);
      if (m_ps) break;
      n++;
      if (n > PERIOD + 2) begin timeout("wait_boundary"); break; end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (m_pend[0]) begin
      cyc(1'b1, 1'b0, 8'h00);
      n++;
      if (n > MAXW) begin timeout("wait_ready"); break; end
    end
  endtask

  task automatic run_to_counter(input int v);
    int n;
    n = 0;
    while (m_t != v) begin
      cyc(1'b1, 1'b0, 8'h00);
      n++;
      if (n > PERIOD + 2) begin timeout("run_to_counter"); break; end
    end
  endtask

  task automatic count_pwm_left(input int ncyc, output int highs);
    highs = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      if (pwm_l[0] === 1'b1) highs++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int         highs;
    logic [7:0] rd;

    rst_n       = 1'b0;
    enable      = 1'b0;
    delta_valid = 1'b0;
    delta       = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);

    // Entering RUN is a boundary loading the reset shadow.
    cyc(1'b1, 1'b0, 8'h00);
`ifndef SLEW_LIMIT_EN
    chk("enter_duty0", 32'({duty_l[0], duty_r[0]}), 32'({8'd128, 8'd128}));
    chk("enter_duty1", 32'({duty_l[1], duty_r[1]}), 32'({8'd200, 8'd200}));
`else
    chk("slew_enter_left", 32'(duty_l[0]), 32'(16));
    send(8'd20);
    for (int k = 2; k <= 10; k++) begin
      wait_boundary();
      chk($sformatf("slew_left_p%0d", k),  32'(duty_l[0]), 32'((k <= 9) ? 16 * k : 148));
      chk($sformatf("slew_right_p%0d", k), 32'(duty_r[0]), 32'((k <= 6) ? 16 * k : 108));
      chk($sformatf("slew_ready_p%0d", k), 32'(rdy[0]),    32'(k == 10));
    end
`endif

    // Nominal mix.
    send(8'd20);
    wait_boundary();
`ifndef SLEW_LIMIT_EN
    chk("nominal_duty0", 32'({duty_l[0], duty_r[0]}), 32'({8'd148, 8'd108}));
    chk("nominal_duty1", 32'({duty_l[1], duty_r[1]}), 32'({8'd220, 8'd180}));
    count_pwm_left(PERIOD, highs);
    chk("nominal_pwm_high_count", 32'(highs), 32'(148));
`endif

    // Saturation.
    wait_ready();
    send(8'h80);
    wait_boundary();
`ifndef SLEW_LIMIT_EN
    chk("sat_neg_duty0", 32'({duty_l[0], duty_r[0]}), 32'({8'd0, 8'd255}));
    count_pwm_left(PERIOD, highs);
    chk("sat_neg_pwm_high_count", 32'(highs), 32'(0));
`endif
    wait_ready();
    send(8'd127);
    wait_boundary();
`ifndef SLEW_LIMIT_EN
    chk("sat_pos_duty1", 32'({duty_l[1], duty_r[1]}), 32'({8'd255, 8'd73}));
    chk("sat_pos_duty0", 32'({duty_l[0], duty_r[0]}), 32'({8'd255, 8'd1}));
`endif

    // Backpressure: second delta held until the first one lands.
    wait_ready();
    send(8'd10);
    chk("bp_ready_low", 32'(rdy[0]), 32'(0));
    send(8'd50);
`ifndef SLEW_LIMIT_EN
    chk("bp_first_applied", 32'({duty_l[0], duty_r[0]}), 32'({8'd138, 8'd118}));
`endif
    wait_boundary();
`ifndef SLEW_LIMIT_EN
    chk("bp_second_applied", 32'({duty_l[0], duty_r[0]}), 32'({8'd178, 8'd78}));
`endif

    // Accept on the boundary edge itself.
    wait_ready();
    run_to_counter(PERIOD - 1);
    cyc(1'b1, 1'b1, 8'd5);
    chk("collide_pstart", 32'(ps[0]), 32'(1));
`ifndef SLEW_LIMIT_EN
    chk("collide_old_kept", 32'({duty_l[0], duty_r[0]}), 32'({8'd178, 8'd78}));
`endif
    wait_boundary();
`ifndef SLEW_LIMIT_EN
    chk("collide_new_applied", 32'({duty_l[0], duty_r[0]}), 32'({8'd133, 8'd123}));
`endif

    // Randomized deltas.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      wait_ready();
      send(rd);
      wait_boundary();
`ifndef SLEW_LIMIT_EN
      chk($sformatf("rand%0d_left", i),  32'(duty_l[0]), 32'(sat(128 + sdelta(rd))));
      chk($sformatf("rand%0d_right", i), 32'(duty_r[0]), 32'(sat(128 - sdelta(rd))));
`endif
      repeat ($urandom_range(0, 40)) cyc(1'b1, 1'b0, 8'h00);
    end

    // Disable mid-period.
    run_to_counter(100);
    cyc(1'b0, 1'b0, 8'h00);
    check_all_zero("disable");
    repeat (3) cyc(1'b0, 1'b1, 8'd7);
    cyc(1'b1, 1'b0, 8'h00);
    wait_ready();
    send(8'd33);
    run_to_counter(60);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
`ifndef SLEW_LIMIT_EN
    chk("post_reset_shadow0", 32'({duty_l[0], duty_r[0]}), 32'({8'd128, 8'd128}));
    chk("post_reset_shadow1", 32'({duty_l[1], duty_r[1]}), 32'({8'd200, 8'd200}));
`endif
    repeat (20) cyc(1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_mixer.md
Name: motor_pwm_mixer

Overview:
- Consumer of the PID `delta` word. Mixes signed steering correction into a base duty: left = base + delta, right = base − delta.
- Generates two glitch-free PWM outputs for the left/right motor drivers.
- Duty updates arrive through a valid/ready handshake and take effect only on PWM period boundaries.

Parameters:
- PWM_BITS, 8, PWM counter and duty width; period = 2^PWM_BITS ticks.
- DELTA_W, 8, width of signed two's-complement delta input.
- BASE_DUTY, 128, nominal duty both motors run at with delta = 0.
- PRESCALE, 4, clk cycles per PWM tick (≥1).
- MAX_STEP, 16, maximum per-period active-duty change; used only with SLEW_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; low forces motors off.
- delta  in  DELTA_W  signed steering correction.
- delta_valid  in  1  delta presented.
- delta_ready  out  1  block can accept delta this cycle.
- pwm_left  out  1  left motor PWM.
- pwm_right  out  1  right motor PWM.
- duty_left  out  PWM_BITS  currently applied left duty.
- duty_right  out  PWM_BITS  currently applied right duty.
- period_start  out  1  one-clk pulse at each PWM period boundary.

Behaviour:
- Reset (async assert, sync release):
  - state = DISABLED; prescaler = 0; PWM counter = 0; pending = 0.
  - Shadow duties = BASE_DUTY; active duties = 0.
  - All outputs = 0.
- FSM, two states:
  - DISABLED: counters held at 0; pwm_* = 0; active duties = 0; delta_ready = 0; no period_start. enable = 1 → RUN on next clk.
  - RUN: enable = 0 → DISABLED on next clk; counters cleared and active duties zeroed that same edge. Shadow and pending are retained.
- Prescaler:
  - Counts 0..PRESCALE−1; tick asserted when count = PRESCALE−1.
  - PWM counter increments on tick and wraps 2^PWM_BITS−1 → 0.
- Period boundary:
  - Occurs on the tick where the PWM counter wraps to 0, and on the first clk after entering RUN.
  - period_start pulses for exactly one clk, on the cycle the counter holds 0.
- Duty update at boundary:
  - Active duties load the shadow value held before that edge; pending clears.
  - Without new deltas, active duties are reloaded with unchanged shadow.
- PWM outputs:
  - pwm_x = registered (cnt < active_x).
  - Duty 0 → constant low; duty 2^PWM_BITS−1 → low for one tick per period.
  - Outputs lag the counter by 1 clk.
- Handshake:
  - delta_ready = (state == RUN) && !pending.
  - Accept when delta_valid && delta_ready: shadow updated and pending set on that edge.
  - delta_valid held while ready = 0 is not consumed.
  - If an accept coincides with a boundary, the boundary loads the old shadow and the new value applies at the next boundary.
- Arithmetic:
  - Sign-extend delta and zero-extend BASE_DUTY to PWM_BITS+2 signed.
  - sum_l = base + delta; sum_r = base − delta.
  - Each result saturates to [0, 2^PWM_BITS−1]. No wrap-around is permitted.
- Reset mid-operation: all state returns to reset values immediately. The pwm_* outputs drop asynchronously.

Optional Feature:
- Macro: SLEW_LIMIT_EN.
- Defined: at each boundary, active_x moves toward shadow_x by at most MAX_STEP.
  - If |shadow − active| ≤ MAX_STEP, active = shadow.
  - pending clears only when both active duties equal shadow. delta_ready stays low until then.
  - Entering RUN ramps up from 0.
- Undefined: active loads shadow directly at the boundary; MAX_STEP is ignored.

Test Plan:
- Nominal mix (PRESCALE=1, BASE=128, no slew): enable = 1; delta = +20 accepted → after next period_start, duty_left = 148, duty_right = 108. pwm_left is high for 148 of 256 clks.
- Saturation:
  - delta = −128 → duty_left = 0 (pwm_left constant low) and duty_right = 255.
  - BASE = 200 with delta = +127 → duty_left = 255, duty_right = 73.
- Handshake backpressure: accept delta = +10, then hold delta_valid with delta = +50 → delta_ready = 0 until the boundary. Duties then become 138/118, +50 is accepted on the next ready, and 178/78 applies one period later.
- Boundary collision: accept delta = +5 on the same clk as period_start → that boundary keeps the previous duties; 133/123 appears at the following boundary.
- Disable/reset mid-period:
  - enable = 0 at counter = 100 → next clk pwm_* = 0, duty_* = 0, delta_ready = 0.
  - rst_n = 0 asynchronously → all outputs 0 within the same cycle; shadow returns to 128.
- SLEW_LIMIT_EN, MAX_STEP = 16: enable with delta = +20 pending → duty_left sequence over successive periods is 16, 32, …, 144, 148. duty_right sequence is 16, …, 96, 108. delta_ready rises after the 148 period.
